// File: rtl/gps_nav_epoch_scheduler.sv
// GPS navigation epoch scheduler: epoch timer plus a load -> solve -> velocity -> integrity
// sequencer that publishes fix_valid/alert once per epoch and counts missed epoch ticks.
module gps_nav_epoch_scheduler #(
  parameter int EPOCH_CYCLES   = 1000,
  parameter int NUM_CH         = 8,
  parameter int MIN_CH         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [NUM_CH-1:0]         ch_valid_i,
  output logic [NUM_CH-1:0]         ch_ack_o,
  output logic                      meas_load_o,
  output logic [$clog2(NUM_CH)-1:0] solver_ch_sel_o,
  output logic                      solve_start_o,
  input  logic                      solve_done_i,
  input  logic                      solve_fail_i,
  output logic                      vel_start_o,
  input  logic                      vel_done_i,
  output logic                      integ_start_o,
  input  logic                      integ_done_i,
  input  logic                      integ_alert_i,
  output logic                      epoch_tick_o,
  output logic                      busy_o,
  output logic                      fix_valid_o,
  output logic                      alert_o,
  output logic [15:0]               overrun_cnt_o
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int EC_W = $clog2(EPOCH_CYCLES);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SOLVE, S_VEL, S_INTEG, S_PUBLISH} state_e;

  state_e            state_q;
  logic [EC_W-1:0]   epoch_cnt_q, epoch_cnt_d;
  logic [15:0]       ovr_q, ovr_d;
  logic [NUM_CH-1:0] pending_q, pick_src, low_oh;
  logic [CH_W-1:0]   low_idx;
  logic              low_found;
  logic [TO_W-1:0]   tmo_q;
  logic              tmo_hit, enough_ch, epoch_tick, busy;
  logic              fix_q, alert_cap_q, fix_valid_q, alert_q;
  logic [NUM_CH-1:0] ch_ack_q;
  logic              meas_load_q, solve_start_q, vel_start_q, integ_start_q;
  logic [CH_W-1:0]   sel_q;

  assign epoch_tick = enable_i && (epoch_cnt_q == EC_W'(EPOCH_CYCLES - 1));
  assign busy       = (state_q != S_IDLE);
  assign tmo_hit    = (tmo_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign enough_ch  = ($countones(ch_valid_i) >= MIN_CH);
  // In IDLE the pick works on the live inputs so the first load can leave with the snapshot.
  assign pick_src   = busy ? pending_q : ch_valid_i;

  always_comb begin
    epoch_cnt_d = '0;
    if (enable_i && !epoch_tick) epoch_cnt_d = epoch_cnt_q + 1'b1;
    ovr_d = ovr_q;
    if (epoch_tick && busy && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
  end

  always_comb begin
    low_idx   = '0;
    low_oh    = '0;
    low_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!low_found && pick_src[k]) begin
        low_found = 1'b1;
        low_idx   = CH_W'(k);
        low_oh[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      epoch_cnt_q <= '0;
      ovr_q       <= '0;
    end else begin
      epoch_cnt_q <= epoch_cnt_d;
      ovr_q       <= ovr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      tmo_q         <= '0;
      fix_q         <= 1'b0;
      alert_cap_q   <= 1'b0;
      fix_valid_q   <= 1'b0;
      alert_q       <= 1'b0;
      ch_ack_q      <= '0;
      meas_load_q   <= 1'b0;
      sel_q         <= '0;
      solve_start_q <= 1'b0;
      vel_start_q   <= 1'b0;
      integ_start_q <= 1'b0;
    end else begin
      ch_ack_q      <= '0;
      meas_load_q   <= 1'b0;
      sel_q         <= '0;
      solve_start_q <= 1'b0;
      vel_start_q   <= 1'b0;
      integ_start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (epoch_tick) begin
          fix_q       <= 1'b0;
          alert_cap_q <= 1'b0;
          if (!enough_ch) begin
            state_q <= S_PUBLISH;
          end else begin
            meas_load_q <= 1'b1;
            sel_q       <= low_idx;
            ch_ack_q    <= low_oh;
            pending_q   <= ch_valid_i & ~low_oh;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: if (|pending_q) begin
          meas_load_q <= 1'b1;
          sel_q       <= low_idx;
          ch_ack_q    <= low_oh;
          pending_q   <= pending_q & ~low_oh;
        end else begin
          solve_start_q <= 1'b1;
          tmo_q         <= '0;
          state_q       <= S_SOLVE;
        end
        S_SOLVE: if (solve_done_i) begin
          if (solve_fail_i) begin
            state_q <= S_PUBLISH;
          end else begin
            vel_start_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= S_VEL;
          end
        end else if (tmo_hit) begin
          alert_cap_q <= 1'b1;
          state_q     <= S_PUBLISH;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        S_VEL: if (vel_done_i) begin
          integ_start_q <= 1'b1;
          tmo_q         <= '0;
          state_q       <= S_INTEG;
        end else if (tmo_hit) begin
          alert_cap_q <= 1'b1;
          state_q     <= S_PUBLISH;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        S_INTEG: if (integ_done_i) begin
          alert_cap_q <= integ_alert_i;
          fix_q       <= 1'b1;
          state_q     <= S_PUBLISH;
        end else if (tmo_hit) begin
          alert_cap_q <= 1'b1;
          state_q     <= S_PUBLISH;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        S_PUBLISH: begin
          fix_valid_q <= fix_q;
          alert_q     <= alert_cap_q;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ch_ack_o        = ch_ack_q;
  assign meas_load_o     = meas_load_q;
  assign solver_ch_sel_o = sel_q;
  assign solve_start_o   = solve_start_q;
  assign vel_start_o     = vel_start_q;
  assign integ_start_o   = integ_start_q;
  assign epoch_tick_o    = epoch_tick;
  assign busy_o          = busy;
  assign fix_valid_o     = fix_valid_q;
  assign alert_o         = alert_q;
  assign overrun_cnt_o   = ovr_q;
endmodule
